artec_dma_dearb: RTL and testbench
==================================

# artec_dma_dearb

Return-path demultiplexer for the DMA engine. It takes a single shared task stream tagged with a channel index, plus a single shared data stream, from the bus-side engine. It fans them back out to `CH_NUM` per-channel task and data streams. For each task it records `{idx, data_num}` in an internal task queue, then steers exactly `data_num` data beats to that channel, in task order. It sits between the AXI read/response engine and the per-channel DMA logic. It is the counterpart of the channel arbiter on the request side.

## Interface
Parameters:
- `CH_NUM`, 4: number of channels.
- `CH_NUM_L`, 2: channel index width, equal to `$clog2(CH_NUM)`.
- `TASK_W`, 32: task payload width.
- `DATA_W`, 64: data beat width.
- `CNT_W`, 8: `data_num` width.
- `TQ_DL`, 2: log2 of the task-queue depth (4 entries).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous flush, with the same effect as `rst`.
- `s_task_valid_i` / `s_task_ready_o`  in/out  1  input task handshake.
- `s_task_idx_i`  in  `CH_NUM_L`  destination channel.
- `s_task_num_i`  in  `CNT_W`  number of data beats belonging to the task (0 means no data).
- `s_task_data_i`  in  `TASK_W`  task payload.
- `s_data_valid_i` / `s_data_ready_o`  in/out  1  input data handshake.
- `s_data_i`  in  `DATA_W`  data beat.
- `m_task_valid_o`  out  `CH_NUM`  one-hot per-channel task valid.
- `m_task_ready_i`  in  `CH_NUM`  per-channel task ready.
- `m_task_data_o`  out  `TASK_W`  task payload, broadcast to all channels.
- `m_data_valid_o`  out  `CH_NUM`  one-hot per-channel data valid.
- `m_data_ready_i`  in  `CH_NUM`  per-channel data ready.
- `m_data_o`  out  `DATA_W`  data beat, broadcast to all channels.

## Operation
- Task output stage: a single register `{t_vld, t_idx, t_data}`. `m_task_valid_o = t_vld << t_idx`. The stage frees on `m_task_ready_i[t_idx]`.
- Task accept condition: `s_task_ready_o = !tq_full && (!t_vld || m_task_ready_i[t_idx])`.
- On task accept:
  - Load the task stage.
  - If `s_task_num_i != 0`, push `{idx, num}` into the task queue (TQ).
  - A zero-num task is forwarded but never pushed.
- Data state machine (`dstate`):
  - IDLE: TQ empty. `s_data_ready_o = 0`. Go to STREAM when TQ is non-empty, loading `rem <= head.num`.
  - STREAM: `s_data_ready_o = !d_vld || m_data_ready_i[d_idx]`.
  - Each data accept loads the data stage `{d_vld=1, d_idx=head.idx, d_data}` and decrements `rem`.
  - An accept with `rem == 1` pops TQ. If another entry remains, reload `rem` from the new head and stay in STREAM; otherwise go to IDLE.
- Data output stage: `m_data_valid_o = d_vld << d_idx`. `d_idx` is latched per beat, so a TQ pop never retargets a beat already in flight.
- Ordering:
  - Beats go out in strict task order.
  - Data for a task may be delivered before that channel accepts its task beat; channels must tolerate this.
- `rem` is `CNT_W` wide and never decrements below 1 while in STREAM.

## Timing
- Reset and `clear_i` (both synchronous):
  - Outputs: all `m_*_valid_o = 0`, `s_data_ready_o = 0`, `s_task_ready_o = 0` during the reset cycle.
  - Internal state: TQ emptied, `dstate = IDLE`.
  - Clearing mid-burst drops all in-flight beats and tasks.
- `s_task_ready_o` goes to 1 on the first cycle after reset deasserts.
- Latency:
  - Task accept at cycle t gives `m_task_valid_o` at t+1.
  - Data accept at cycle t gives `m_data_valid_o` at t+1.
- Throughput: one task per cycle and one beat per cycle, sustained while the destination ready stays high (pass-through on drain).
- Task pushed into an empty TQ at cycle t: the head becomes visible at t+1, and `s_data_ready_o` can first be 1 at t+1.
- A simultaneous TQ push and pop in the same cycle is legal. TQ occupancy is unchanged, and the full flag is unaffected.
- TQ full: `s_task_ready_o = 0`. TQ pointers wrap modulo `2^TQ_DL`.
- Stalled destination: the stage holds `valid`, `idx` and `data` stable until ready. The opposite path is not blocked.

## Test plan
- Single task, ch2, num=3, beats A, B, C, all readies high → `m_task_valid_o = 4'b0100` at t+1. Beats A, B, C appear on `m_data_valid_o = 4'b0100` on three consecutive cycles. TQ ends empty and `s_data_ready_o` returns to 0.
- Back-to-back tasks ch0 num=2 then ch3 num=1, continuous data → beats 1–2 go to ch0 and beat 3 goes to ch3, with no bubble between beat 2 and beat 3.
- Five tasks (num=1) pushed with no data → the 5th is refused, with `s_task_ready_o = 0` after 4 TQ entries. One data accept reasserts `s_task_ready_o` the next cycle.
- Task with num=0 to ch1 → `m_task_valid_o[1]` pulses, TQ occupancy stays 0, and `s_data_ready_o` stays 0.
- `m_data_ready_i[1]` held low for 5 cycles mid-burst on ch1 → `m_data_o` is stable and `s_data_ready_o = 0` while stalled. The burst resumes with no lost or duplicated beats.
- `clear_i` pulsed after 1 of 4 beats → all valids are 0 the next cycle, TQ is empty, and the next task is routed correctly from a clean state.

Source files
------------

// File: rtl/artec_dma_dearb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// artec_dma_dearb: fans a channel-tagged task/data return stream out to
// CH_NUM per-channel task and data streams, in task order.   Rev 1.0
// ---------------------------------------------------------------------------
module artec_dma_dearb #(
  parameter int CH_NUM   = 4,
  parameter int CH_NUM_L = 2,
  parameter int TASK_W   = 32,
  parameter int DATA_W   = 64,
  parameter int CNT_W    = 8,
  parameter int TQ_DL    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                s_task_valid_i,
  output logic                s_task_ready_o,
  input  logic [CH_NUM_L-1:0] s_task_idx_i,
  input  logic [CNT_W-1:0]    s_task_num_i,
  input  logic [TASK_W-1:0]   s_task_data_i,
  input  logic                s_data_valid_i,
  output logic                s_data_ready_o,
  input  logic [DATA_W-1:0]   s_data_i,
  output logic [CH_NUM-1:0]   m_task_valid_o,
  input  logic [CH_NUM-1:0]   m_task_ready_i,
  output logic [TASK_W-1:0]   m_task_data_o,
  output logic [CH_NUM-1:0]   m_data_valid_o,
  input  logic [CH_NUM-1:0]   m_data_ready_i,
  output logic [DATA_W-1:0]   m_data_o
);

  localparam int             TQ_DEPTH    = 1 << TQ_DL;
  localparam logic [TQ_DL:0] TQ_CNT_FULL = (TQ_DL+1)'(TQ_DEPTH);
  localparam logic [TQ_DL:0] TQ_CNT_ONE  = (TQ_DL+1)'(1);

  typedef enum logic [0:0] {
    DS_IDLE   = 1'b0,
    DS_STREAM = 1'b1
  } dstate_e;

  logic                flush;

  logic                t_vld_q;
  logic [CH_NUM_L-1:0] t_idx_q;
  logic [TASK_W-1:0]   t_data_q;

  logic                d_vld_q;
  logic [CH_NUM_L-1:0] d_idx_q;
  logic [DATA_W-1:0]   d_data_q;

  logic [CH_NUM_L-1:0] tq_idx_q [TQ_DEPTH];
  logic [CNT_W-1:0]    tq_num_q [TQ_DEPTH];
  logic [TQ_DL-1:0]    tq_wr_q;
  logic [TQ_DL-1:0]    tq_rd_q;
  logic [TQ_DL-1:0]    tq_rd_nxt;
  logic [TQ_DL:0]      tq_cnt_q;
  logic [TQ_DL:0]      tq_cnt_d;

  dstate_e             dstate_q;
  logic [CNT_W-1:0]    rem_q;

  logic t_free;
  logic d_free;
  logic tq_full;
  logic tq_more;
  logic task_acc;
  logic data_acc;
  logic rem_last;
  logic tq_push;
  logic tq_pop;

  assign flush     = rst | clear_i;
  assign t_free    = !t_vld_q || m_task_ready_i[t_idx_q];
  assign d_free    = !d_vld_q || m_data_ready_i[d_idx_q];
  assign tq_full   = (tq_cnt_q == TQ_CNT_FULL);
  assign tq_more   = (tq_cnt_q > TQ_CNT_ONE);
  assign rem_last  = (rem_q == CNT_W'(1));
  assign tq_rd_nxt = tq_rd_q + TQ_DL'(1);

  assign s_task_ready_o = !flush && !tq_full && t_free;
  assign s_data_ready_o = !flush && (dstate_q == DS_STREAM) && d_free;

  assign task_acc = s_task_valid_i && s_task_ready_o;
  assign data_acc = s_data_valid_i && s_data_ready_o;
  // Zero-beat tasks are forwarded but never occupy a queue slot.
  assign tq_push  = task_acc && (s_task_num_i != '0);
  assign tq_pop   = data_acc && rem_last;

  always_comb begin
    tq_cnt_d = tq_cnt_q;
    if (tq_push && !tq_pop) begin
      tq_cnt_d = tq_cnt_q + TQ_CNT_ONE;
    end else if (!tq_push && tq_pop) begin
      tq_cnt_d = tq_cnt_q - TQ_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      tq_wr_q  <= '0;
      tq_rd_q  <= '0;
      tq_cnt_q <= '0;
    end else begin
      tq_cnt_q <= tq_cnt_d;
      if (tq_push) tq_wr_q <= tq_wr_q + TQ_DL'(1);
      if (tq_pop)  tq_rd_q <= tq_rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (tq_push) begin
      tq_idx_q[tq_wr_q] <= s_task_idx_i;
      tq_num_q[tq_wr_q] <= s_task_num_i;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      t_vld_q  <= 1'b0;
      t_idx_q  <= '0;
      t_data_q <= '0;
    end else if (task_acc) begin
      t_vld_q  <= 1'b1;
      t_idx_q  <= s_task_idx_i;
      t_data_q <= s_task_data_i;
    end else if (t_vld_q && m_task_ready_i[t_idx_q]) begin
      t_vld_q  <= 1'b0;
    end
  end

  // Destination is latched per beat so a queue pop cannot retarget it.
  always_ff @(posedge clk) begin
    if (flush) begin
      d_vld_q  <= 1'b0;
      d_idx_q  <= '0;
      d_data_q <= '0;
    end else if (data_acc) begin
      d_vld_q  <= 1'b1;
      d_idx_q  <= tq_idx_q[tq_rd_q];
      d_data_q <= s_data_i;
    end else if (d_vld_q && m_data_ready_i[d_idx_q]) begin
      d_vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      dstate_q <= DS_IDLE;
      rem_q    <= '0;
    end else begin
      case (dstate_q)
        DS_IDLE: begin
          // Enter STREAM on the push itself so the head is usable next cycle.
          if (tq_push) begin
            dstate_q <= DS_STREAM;
            rem_q    <= s_task_num_i;
          end
        end
        DS_STREAM: begin
          if (data_acc) begin
            if (rem_last) begin
              if (tq_more) begin
                rem_q <= tq_num_q[tq_rd_nxt];
              end else if (tq_push) begin
                rem_q <= s_task_num_i;
              end else begin
                dstate_q <= DS_IDLE;
                rem_q    <= '0;
              end
            end else begin
              rem_q <= rem_q - CNT_W'(1);
            end
          end
        end
        default: begin
          dstate_q <= DS_IDLE;
          rem_q    <= '0;
        end
      endcase
    end
  end

  assign m_task_valid_o = flush ? '0 : (CH_NUM'(t_vld_q) << t_idx_q);
  assign m_task_data_o  = t_data_q;
  assign m_data_valid_o = flush ? '0 : (CH_NUM'(d_vld_q) << d_idx_q);
  assign m_data_o       = d_data_q;

endmodule
`default_nettype wire

// File: tb/tb_artec_dma_dearb.sv
`default_nettype none
// tb_artec_dma_dearb: vector table, corner sequences and randomized traffic
// checked every cycle against a task/beat queue model.
module tb_artec_dma_dearb;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_i;
  logic        s_task_valid_i;
  logic        s_task_ready_o;
  logic [1:0]  s_task_idx_i;
  logic [7:0]  s_task_num_i;
  logic [31:0] s_task_data_i;
  logic        s_data_valid_i;
  logic        s_data_ready_o;
  logic [63:0] s_data_i;
  logic [3:0]  m_task_valid_o;
  logic [3:0]  m_task_ready_i;
  logic [31:0] m_task_data_o;
  logic [3:0]  m_data_valid_o;
  logic [3:0]  m_data_ready_i;
  logic [63:0] m_data_o;

  always #5 clk = ~clk;

  artec_dma_dearb #(
    .CH_NUM(4), .CH_NUM_L(2), .TASK_W(32), .DATA_W(64), .CNT_W(8), .TQ_DL(2)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .s_task_valid_i(s_task_valid_i), .s_task_ready_o(s_task_ready_o),
    .s_task_idx_i(s_task_idx_i), .s_task_num_i(s_task_num_i),
    .s_task_data_i(s_task_data_i),
    .s_data_valid_i(s_data_valid_i), .s_data_ready_o(s_data_ready_o),
    .s_data_i(s_data_i),
    .m_task_valid_o(m_task_valid_o), .m_task_ready_i(m_task_ready_i),
    .m_task_data_o(m_task_data_o),
    .m_data_valid_o(m_data_valid_o), .m_data_ready_i(m_data_ready_i),
    .m_data_o(m_data_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: tasks awaiting channel pickup, beats awaiting channel pickup,
  // and tasks still owed data beats (channel, beats left).
  logic [1:0]  to_idx[$];
  logic [31:0] to_data[$];
  logic [1:0]  do_idx[$];
  logic [63:0] do_data[$];
  logic [1:0]  pd_idx[$];
  int          pd_rem[$];

  typedef struct {
    logic        tv;
    logic [1:0]  tidx;
    logic [7:0]  tnum;
    logic [31:0] tdata;
    logic        dv;
    logic [63:0] ddata;
    logic [3:0]  e_tv;
    logic [3:0]  e_dv;
    logic [63:0] e_d;
    logic        e_str;
    logic        e_sdr;
  } vec_t;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic       flush;
    logic [3:0] e_tv;
    logic [3:0] e_dv;
    logic       e_str;
    logic       e_sdr;
    flush = rst || clear_i;
    e_tv  = 4'b0000;
    e_dv  = 4'b0000;
    e_str = 1'b0;
    e_sdr = 1'b0;
    if (!flush) begin
      if (to_idx.size() > 0) e_tv = 4'b0001 << to_idx[0];
      if (do_idx.size() > 0) e_dv = 4'b0001 << do_idx[0];
      if (pd_idx.size() < 4) begin
        if (to_idx.size() == 0) e_str = 1'b1;
        else e_str = m_task_ready_i[to_idx[0]];
      end
      if (pd_idx.size() > 0) begin
        if (do_idx.size() == 0) e_sdr = 1'b1;
        else e_sdr = m_data_ready_i[do_idx[0]];
      end
    end
    cmp("m_task_valid", 64'(m_task_valid_o), 64'(e_tv));
    cmp("m_data_valid", 64'(m_data_valid_o), 64'(e_dv));
    cmp("s_task_ready", 64'(s_task_ready_o), 64'(e_str));
    cmp("s_data_ready", 64'(s_data_ready_o), 64'(e_sdr));
    if (e_tv != 4'b0000) cmp("m_task_data", 64'(m_task_data_o), 64'(to_data[0]));
    if (e_dv != 4'b0000) cmp("m_data", m_data_o, do_data[0]);
    if (flush) begin
      to_idx.delete(); to_data.delete();
      do_idx.delete(); do_data.delete();
      pd_idx.delete(); pd_rem.delete();
    end else begin
      if (to_idx.size() > 0 && m_task_ready_i[to_idx[0]]) begin
        void'(to_idx.pop_front()); void'(to_data.pop_front());
      end
      if (do_idx.size() > 0 && m_data_ready_i[do_idx[0]]) begin
        void'(do_idx.pop_front()); void'(do_data.pop_front());
      end
      if (s_data_valid_i && e_sdr) begin
        do_idx.push_back(pd_idx[0]);
        do_data.push_back(s_data_i);
        pd_rem[0] = pd_rem[0] - 1;
        if (pd_rem[0] == 0) begin
          void'(pd_idx.pop_front()); void'(pd_rem.pop_front());
        end
      end
      if (s_task_valid_i && e_str) begin
        to_idx.push_back(s_task_idx_i);
        to_data.push_back(s_task_data_i);
        if (s_task_num_i != 8'd0) begin
          pd_idx.push_back(s_task_idx_i);
          pd_rem.push_back(int'(s_task_num_i));
        end
      end
    end
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic close_cycle();
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    clear_i = 1'b0; s_task_valid_i = 1'b0; s_data_valid_i = 1'b0;
    m_task_ready_i = 4'hF; m_data_ready_i = 4'hF;
  endtask

  task automatic drain(input string name);
    quiet();
    s_data_valid_i = 1'b1;
    for (int k = 0; k < 100 && pd_idx.size() > 0; k++) begin
      s_data_i = {$urandom, $urandom};
      to_check(); close_cycle();
    end
    s_data_valid_i = 1'b0;
    repeat (3) begin to_check(); close_cycle(); end
    cmp({name, "_drained"}, 64'(pd_idx.size()), 64'd0);
    to_check();
    cmp({name, "_idle_dready"}, 64'(s_data_ready_o), 64'd0);
    close_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    rst = 1'b1;
    quiet();
    s_task_idx_i = '0; s_task_num_i = '0; s_task_data_i = '0; s_data_i = '0;
    repeat (2) begin to_check(); close_cycle(); end
    rst = 1'b0;

    //           tv   idx  num  tdata        dv   ddata  e_tv     e_dv     e_d    str  sdr
    tbl[0]  = '{1'b1, 2'd2, 8'd3, 32'h2222_0003, 1'b0, 64'h00, 4'b0000, 4'b0000, 64'h00, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b1, 64'h0A, 4'b0100, 4'b0000, 64'h00, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b1, 64'h0B, 4'b0000, 4'b0100, 64'h0A, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b1, 64'h0C, 4'b0000, 4'b0100, 64'h0B, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b0, 64'h00, 4'b0000, 4'b0100, 64'h0C, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b0, 64'h00, 4'b0000, 4'b0000, 64'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 8'd2, 32'h0000_0002, 1'b0, 64'h00, 4'b0000, 4'b0000, 64'h00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 8'd1, 32'h3333_0001, 1'b1, 64'h11, 4'b0001, 4'b0000, 64'h00, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b1, 64'h12, 4'b1000, 4'b0001, 64'h11, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b1, 64'h13, 4'b0000, 4'b0001, 64'h12, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b0, 64'h00, 4'b0000, 4'b1000, 64'h13, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'd1, 8'd0, 32'h1111_0000, 1'b0, 64'h00, 4'b0000, 4'b0000, 64'h00, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b0, 64'h00, 4'b0010, 4'b0000, 64'h00, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 8'd0, 32'h0,         1'b0, 64'h00, 4'b0000, 4'b0000, 64'h00, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      s_task_valid_i = tbl[i].tv;    s_task_idx_i = tbl[i].tidx;
      s_task_num_i   = tbl[i].tnum;  s_task_data_i = tbl[i].tdata;
      s_data_valid_i = tbl[i].dv;    s_data_i = tbl[i].ddata;
      to_check();
      cmp($sformatf("tbl%0d_task_valid", i), 64'(m_task_valid_o), 64'(tbl[i].e_tv));
      cmp($sformatf("tbl%0d_data_valid", i), 64'(m_data_valid_o), 64'(tbl[i].e_dv));
      if (tbl[i].e_dv != 4'b0000) cmp($sformatf("tbl%0d_data", i), m_data_o, tbl[i].e_d);
      cmp($sformatf("tbl%0d_task_ready", i), 64'(s_task_ready_o), 64'(tbl[i].e_str));
      cmp($sformatf("tbl%0d_data_ready", i), 64'(s_data_ready_o), 64'(tbl[i].e_sdr));
      close_cycle();
    end

    // Queue fills after four single-beat tasks; one beat frees a slot.
    quiet();
    for (int k = 0; k < 6; k++) begin
      s_task_valid_i = 1'b1;
      s_task_idx_i   = 2'(k < 4 ? k : 1);
      s_task_num_i   = 8'd1;
      s_task_data_i  = 32'hF000_0000 + 32'(k < 4 ? k : 4);
      to_check();
      cmp($sformatf("full_task_ready_%0d", k), 64'(s_task_ready_o), 64'(k < 4));
      close_cycle();
    end
    s_data_valid_i = 1'b1; s_data_i = 64'h77;
    to_check();
    cmp("full_task_ready_held", 64'(s_task_ready_o), 64'd0);
    cmp("full_data_ready", 64'(s_data_ready_o), 64'd1);
    close_cycle();
    s_data_valid_i = 1'b0;
    to_check();
    cmp("full_task_ready_back", 64'(s_task_ready_o), 64'd1);
    close_cycle();
    drain("full");

    // Channel 1 stalls for five cycles mid-burst.
    quiet();
    s_task_valid_i = 1'b1; s_task_idx_i = 2'd1; s_task_num_i = 8'd6; s_task_data_i = 32'h5151_0006;
    to_check(); close_cycle();
    s_task_valid_i = 1'b0; s_data_valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_data_i = 64'h5100 + 64'(c);
      m_data_ready_i = (c >= 3 && c < 8) ? 4'b1101 : 4'b1111;
      to_check();
      if (c >= 3 && c < 8) begin
        cmp("stall_data_ready", 64'(s_data_ready_o), 64'd0);
        cmp("stall_hold_data", m_data_o, 64'h5102);
        cmp("stall_hold_valid", 64'(m_data_valid_o), 64'b0010);
      end
      close_cycle();
    end
    drain("stall");

    // Flush after the first of four beats, then route a fresh task.
    quiet();
    s_task_valid_i = 1'b1; s_task_idx_i = 2'd2; s_task_num_i = 8'd4; s_task_data_i = 32'hC1C1_0004;
    to_check(); close_cycle();
    s_task_valid_i = 1'b0; s_data_valid_i = 1'b1; s_data_i = 64'hC1;
    to_check(); close_cycle();
    s_data_valid_i = 1'b0; clear_i = 1'b1;
    to_check();
    cmp("clr_task_valid", 64'(m_task_valid_o), 64'd0);
    cmp("clr_data_valid", 64'(m_data_valid_o), 64'd0);
    cmp("clr_task_ready", 64'(s_task_ready_o), 64'd0);
    close_cycle();
    clear_i = 1'b0;
    to_check();
    cmp("post_clr_data_valid", 64'(m_data_valid_o), 64'd0);
    cmp("post_clr_data_ready", 64'(s_data_ready_o), 64'd0);
    cmp("post_clr_task_ready", 64'(s_task_ready_o), 64'd1);
    close_cycle();
    s_task_valid_i = 1'b1; s_task_idx_i = 2'd3; s_task_num_i = 8'd1; s_task_data_i = 32'hC5C5_0001;
    to_check(); close_cycle();
    s_task_valid_i = 1'b0; s_data_valid_i = 1'b1; s_data_i = 64'hC5;
    to_check();
    cmp("post_clr_ready_new", 64'(s_data_ready_o), 64'd1);
    close_cycle();
    s_data_valid_i = 1'b0;
    to_check();
    cmp("post_clr_route", 64'(m_data_valid_o), 64'b1000);
    cmp("post_clr_beat", m_data_o, 64'hC5);
    close_cycle();
    drain("clear");

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      clear_i        = ($urandom_range(0, 249) == 0);
      s_task_valid_i = ($urandom_range(0, 9) < 4);
      s_task_idx_i   = 2'($urandom_range(0, 3));
      s_task_num_i   = 8'($urandom_range(0, 4));
      s_task_data_i  = $urandom;
      s_data_valid_i = ($urandom_range(0, 9) < 7);
      s_data_i       = {$urandom, $urandom};
      m_task_ready_i = 4'($urandom) | 4'($urandom);
      m_data_ready_i = 4'($urandom) | 4'($urandom);
      to_check(); close_cycle();
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
